// File: rtl/fat32_pkg.sv
// FAT32 boot-record parser shared definitions: FSM states, error codes,
// MBR/BPB byte offsets, partition type codes and small helpers.
package fat32_pkg;

    typedef enum logic [3:0] {
        IDLE, REQ0, RX0, CHK0, REQV, RXV, CHKV, MUL, SUM, DONE, ERR
    } state_t;

    localparam logic [2:0] E_SIG0   = 3'd1;
    localparam logic [2:0] E_NOPART = 3'd2;
    localparam logic [2:0] E_SIGV   = 3'd3;
    localparam logic [2:0] E_BPB    = 3'd4;

    localparam logic [15:0] OFF_PTABLE = 16'h01BE;
    localparam logic [15:0] OFF_BPS    = 16'h000B;
    localparam logic [15:0] OFF_SPC    = 16'h000D;
    localparam logic [15:0] OFF_RSVD   = 16'h000E;
    localparam logic [15:0] OFF_NFATS  = 16'h0010;
    localparam logic [15:0] OFF_FATSZ  = 16'h0024;
    localparam logic [15:0] OFF_ROOTCL = 16'h002C;
    localparam logic [15:0] OFF_SIG    = 16'h01FE;

    localparam logic [15:0] BOOT_SIG       = 16'hAA55;
    localparam logic [7:0]  TYPE_FAT32_CHS = 8'h0B;
    localparam logic [7:0]  TYPE_FAT32_LBA = 8'h0C;
    localparam logic [7:0]  JMP_SHORT      = 8'hEB;
    localparam logic [7:0]  JMP_NEAR       = 8'hE9;

    // Byte lane of a little-endian multi-byte field starting at base.
    function automatic logic [1:0] lane(input logic [15:0] i, input logic [15:0] base);
        return 2'(i - base);
    endfunction

    function automatic logic [2:0] log2_pow2(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

endpackage

// File: rtl/shift_add_mul8x32.sv
// Serial 8-bit x W-bit multiplier, one multiplier bit per cycle.
// done marks the final iteration; product is valid from the following cycle.
module shift_add_mul8x32 #(
    parameter int W = 32
) (
    input  logic         Clock,
    input  logic         sys_rst_n,
    input  logic         start,
    input  logic [7:0]   a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] product
);

    logic [W-1:0] mcand;
    logic [W-1:0] acc;
    logic [7:0]   mplier;
    logic [3:0]   cnt;

    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= b;
            acc    <= '0;
            mplier <= a;
            cnt    <= 4'd8;
        end else if (cnt != 4'd0) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 4'd1;
        end
    end

    assign done    = (cnt == 4'd1);
    assign product = acc;

endmodule

// File: rtl/fat32_boot_parser.sv
// Reads sector 0 and the selected volume boot record from a byte stream,
// validates them and derives the absolute FAT32 region LBAs.
module fat32_boot_parser
    import fat32_pkg::*;
#(
    parameter int PARTITION_INDEX = 0,
    parameter int SECTOR_BYTES    = 512,
    parameter int INDEX_WIDTH     = 9,
    parameter int LBA_WIDTH       = 32
) (
    input  logic                   Clock,
    input  logic                   sys_rst_n,
    input  logic                   start,
    output logic                   sector_req,
    output logic [LBA_WIDTH-1:0]   sector_lba,
    input  logic                   byte_valid,
    input  logic [INDEX_WIDTH-1:0] byte_index,
    input  logic [7:0]             byte_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [2:0]             error_code,
    output logic [LBA_WIDTH-1:0]   partition_lba,
    output logic [LBA_WIDTH-1:0]   fat_begin_lba,
    output logic [LBA_WIDTH-1:0]   data_begin_lba,
    output logic [LBA_WIDTH-1:0]   root_dir_lba,
    output logic [LBA_WIDTH-1:0]   root_cluster,
    output logic [LBA_WIDTH-1:0]   fat_size,
    output logic [15:0]            reserved_sectors,
    output logic [7:0]             sectors_per_cluster,
    output logic [7:0]             num_fats
);

    localparam logic [15:0] ENT = OFF_PTABLE + 16'(16 * PARTITION_INDEX);

    state_t state;
    logic [7:0]  byte0, ptype, spc, nfats;
    logic [15:0] sig, bps, rsvd, idx;
    logic [31:0] plba, fsz, rcl, rc_adj;
    logic        accept, rx, last, spc_ok, bpb_ok, mul_start, mul_done;
    logic [LBA_WIDTH-1:0] product, fat_b, data_b, root_b;

    assign idx    = 16'(byte_index);
    assign accept = start && (state == IDLE || state == DONE || state == ERR);
    assign rx     = byte_valid && (state == RX0 || state == RXV);
    assign last   = byte_valid && (idx == OFF_SIG + 16'd1);
    assign spc_ok = (spc != 8'd0) && ((spc & (spc - 8'd1)) == 8'd0);
    assign bpb_ok = (bps == 16'(SECTOR_BYTES)) && (nfats != 8'd0) && spc_ok;

    // Cluster numbering starts at 2; anything lower maps to the first cluster.
    assign rc_adj = (rcl < 32'd2) ? 32'd0 : rcl - 32'd2;
    assign fat_b  = partition_lba + LBA_WIDTH'(rsvd);
    assign data_b = fat_b + product;
    assign root_b = data_b + (LBA_WIDTH'(rc_adj) << log2_pow2(spc));

    assign mul_start = (state == CHKV);

    shift_add_mul8x32 #(.W(LBA_WIDTH)) u_mul (
        .Clock     (Clock),
        .sys_rst_n (sys_rst_n),
        .start     (mul_start),
        .a         (nfats),
        .b         (LBA_WIDTH'(fsz)),
        .done      (mul_done),
        .product   (product)
    );

    assign root_cluster        = LBA_WIDTH'(rcl);
    assign fat_size            = LBA_WIDTH'(fsz);
    assign reserved_sectors    = rsvd;
    assign sectors_per_cluster = spc;
    assign num_fats            = nfats;

    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte0 <= '0; ptype <= '0; spc <= '0; nfats <= '0;
            sig   <= '0; bps   <= '0; rsvd <= '0;
            plba  <= '0; fsz   <= '0; rcl <= '0;
        end else if (accept) begin
            byte0 <= '0; ptype <= '0; spc <= '0; nfats <= '0;
            sig   <= '0; bps   <= '0; rsvd <= '0;
            plba  <= '0; fsz   <= '0; rcl <= '0;
        end else if (rx) begin
            case (idx)
                16'h0000:             byte0      <= byte_data;
                OFF_BPS:              bps[7:0]   <= byte_data;
                OFF_BPS + 16'd1:      bps[15:8]  <= byte_data;
                OFF_SPC:              spc        <= byte_data;
                OFF_RSVD:             rsvd[7:0]  <= byte_data;
                OFF_RSVD + 16'd1:     rsvd[15:8] <= byte_data;
                OFF_NFATS:            nfats      <= byte_data;
                OFF_SIG:              sig[7:0]   <= byte_data;
                OFF_SIG + 16'd1:      sig[15:8]  <= byte_data;
                default: ;
            endcase
            if (idx >= OFF_FATSZ && idx < OFF_FATSZ + 16'd4)
                fsz[{lane(idx, OFF_FATSZ), 3'b000} +: 8] <= byte_data;
            if (idx >= OFF_ROOTCL && idx < OFF_ROOTCL + 16'd4)
                rcl[{lane(idx, OFF_ROOTCL), 3'b000} +: 8] <= byte_data;
            if (idx == ENT + 16'd4)
                ptype <= byte_data;
            if (idx >= ENT + 16'd8 && idx < ENT + 16'd12)
                plba[{lane(idx, ENT + 16'd8), 3'b000} +: 8] <= byte_data;
        end
    end

    always_ff @(posedge Clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            sector_req     <= 1'b0;
            sector_lba     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            error_code     <= '0;
            partition_lba  <= '0;
            fat_begin_lba  <= '0;
            data_begin_lba <= '0;
            root_dir_lba   <= '0;
        end else begin
            sector_req <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: if (start) begin
                    state          <= REQ0;
                    sector_req     <= 1'b1;
                    sector_lba     <= '0;
                    busy           <= 1'b1;
                    done           <= 1'b0;
                    error          <= 1'b0;
                    error_code     <= '0;
                    partition_lba  <= '0;
                    fat_begin_lba  <= '0;
                    data_begin_lba <= '0;
                    root_dir_lba   <= '0;
                end
                REQ0: state <= RX0;
                RX0:  if (last) state <= CHK0;
                CHK0: begin
                    if (sig != BOOT_SIG) begin
                        state <= ERR; error <= 1'b1;
                        busy  <= 1'b0; error_code <= E_SIG0;
                    end else if (ptype == TYPE_FAT32_CHS || ptype == TYPE_FAT32_LBA) begin
                        partition_lba <= LBA_WIDTH'(plba);
                        sector_lba    <= LBA_WIDTH'(plba);
                        sector_req    <= 1'b1;
                        state         <= REQV;
                    end else if (byte0 == JMP_SHORT || byte0 == JMP_NEAR) begin
                        // Superfloppy: sector 0 already holds the BPB.
                        partition_lba <= '0;
                        state         <= CHKV;
                    end else begin
                        state <= ERR; error <= 1'b1;
                        busy  <= 1'b0; error_code <= E_NOPART;
                    end
                end
                REQV: state <= RXV;
                RXV:  if (last) state <= CHKV;
                CHKV: begin
                    if (sig != BOOT_SIG) begin
                        state <= ERR; error <= 1'b1;
                        busy  <= 1'b0; error_code <= E_SIGV;
                    end else if (!bpb_ok) begin
                        state <= ERR; error <= 1'b1;
                        busy  <= 1'b0; error_code <= E_BPB;
                    end else begin
                        state <= MUL;
                    end
                end
                MUL: if (mul_done) state <= SUM;
                SUM: begin
                    fat_begin_lba  <= fat_b;
                    data_begin_lba <= data_b;
                    root_dir_lba   <= root_b;
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    state          <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fat32_boot_parser.sv
// Directed bench for fat32_boot_parser: MBR, superfloppy, error paths, reset abort.
module tb_fat32_boot_parser;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic sys_rst_n, start0, start1, byte_valid;
    logic [8:0] byte_index;
    logic [7:0] byte_data;

    logic sreq0, busy0, done0, err0;
    logic [2:0] code0;
    logic [31:0] slba0, plba0, fatb0, datab0, root0, rc0, fs0;
    logic [15:0] rs0;
    logic [7:0] spc0, nf0;

    logic sreq1, busy1, done1, err1;
    logic [2:0] code1;
    logic [31:0] slba1, plba1, fatb1, datab1, root1, rc1, fs1;
    logic [15:0] rs1;
    logic [7:0] spc1, nf1;

    logic sel;
    logic req_s, busy_s, done_s, err_s;
    logic [31:0] slba_s;
    assign req_s  = sel ? sreq1 : sreq0;
    assign busy_s = sel ? busy1 : busy0;
    assign done_s = sel ? done1 : done0;
    assign err_s  = sel ? err1  : err0;
    assign slba_s = sel ? slba1 : slba0;

    fat32_boot_parser #(.PARTITION_INDEX(0)) dut (
        .Clock(Clock), .sys_rst_n(sys_rst_n), .start(start0),
        .sector_req(sreq0), .sector_lba(slba0),
        .byte_valid(byte_valid), .byte_index(byte_index), .byte_data(byte_data),
        .busy(busy0), .done(done0), .error(err0), .error_code(code0),
        .partition_lba(plba0), .fat_begin_lba(fatb0), .data_begin_lba(datab0),
        .root_dir_lba(root0), .root_cluster(rc0), .fat_size(fs0),
        .reserved_sectors(rs0), .sectors_per_cluster(spc0), .num_fats(nf0)
    );

    fat32_boot_parser #(.PARTITION_INDEX(1)) dut1 (
        .Clock(Clock), .sys_rst_n(sys_rst_n), .start(start1),
        .sector_req(sreq1), .sector_lba(slba1),
        .byte_valid(byte_valid), .byte_index(byte_index), .byte_data(byte_data),
        .busy(busy1), .done(done1), .error(err1), .error_code(code1),
        .partition_lba(plba1), .fat_begin_lba(fatb1), .data_begin_lba(datab1),
        .root_dir_lba(root1), .root_cluster(rc1), .fat_size(fs1),
        .reserved_sectors(rs1), .sectors_per_cluster(spc1), .num_fats(nf1)
    );

    logic [7:0] img0 [512];
    logic [7:0] img1 [512];
    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 512; i++) begin
            img0[i] = 8'h00;
            img1[i] = 8'h00;
        end
    endtask

    task automatic put(input int w, input int off, input int n, input logic [31:0] v);
        for (int k = 0; k < n; k++)
            if (w == 0) img0[off + k] = v[8*k +: 8];
            else        img1[off + k] = v[8*k +: 8];
    endtask

    task automatic mbr(input int p, input logic [7:0] t, input logic [31:0] lba);
        put(0, 16'h1BE + 16*p + 4, 1, {24'd0, t});
        put(0, 16'h1BE + 16*p + 8, 4, lba);
        put(0, 510, 2, 32'hAA55);
    endtask

    task automatic vbr(input int w, input int res, input int nf, input int fs,
                       input int spc, input int rc);
        put(w, 0, 1, 32'hEB);
        put(w, 16'h0B, 2, 32'd512);
        put(w, 16'h0D, 1, spc);
        put(w, 16'h0E, 2, res);
        put(w, 16'h10, 1, nf);
        put(w, 16'h24, 4, fs);
        put(w, 16'h2C, 4, rc);
        put(w, 510, 2, 32'hAA55);
    endtask

    task automatic stream(input int w, input int n);
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            byte_index = 9'(i);
            byte_data  = (w == 0) ? img0[i] : img1[i];
            @(posedge Clock); #1;
        end
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic s);
        sel = s;
        @(posedge Clock); #1;
        if (s) start1 = 1'b1; else start0 = 1'b1;
        @(posedge Clock); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        check("req_next_cycle", {31'd0, req_s}, 32'd1);
        check("busy_after_start", {31'd0, busy_s}, 32'd1);
        check("flags_cleared", {30'd0, done_s, err_s}, 32'd0);
    endtask

    task automatic wait_req();
        int g;
        g = 0;
        while (!req_s && g < 100) begin
            @(posedge Clock); #1;
            g++;
        end
        check("req_seen", {31'd0, req_s}, 32'd1);
    endtask

    task automatic run(input logic s, output int nreq, output logic [31:0] lba2, output int lat);
        int guard, w;
        nreq = 0; lba2 = 0; lat = 0; guard = 0;
        pulse_start(s);
        while (!(done_s || err_s) && guard < 3000 && nreq < 4) begin
            if (req_s) begin
                nreq++;
                if (nreq == 2) lba2 = slba_s;
                w = (slba_s == 0) ? 0 : 1;
                @(posedge Clock); #1;
                stream(w, 512);
                lat = 0;
            end else begin
                @(posedge Clock); #1;
                lat++;
                guard++;
            end
        end
        check("finished_in_budget", {31'd0, done_s || err_s}, 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, {25'd0, sreq0, busy0, done0, err0, code0}, 32'd0);
        check({tag, "_sector_lba"}, slba0, 32'd0);
        check({tag, "_partition"}, plba0, 32'd0);
        check({tag, "_fat_begin"}, fatb0, 32'd0);
        check({tag, "_data_begin"}, datab0, 32'd0);
        check({tag, "_root_dir"}, root0, 32'd0);
        check({tag, "_root_cl"}, rc0, 32'd0);
        check({tag, "_fat_size"}, fs0, 32'd0);
        check({tag, "_rs_spc_nf"}, {rs0, spc0, nf0}, 32'd0);
    endtask

    int nreq, lat;
    logic [31:0] lba2;

    initial begin
        sys_rst_n = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
        byte_valid = 1'b0; byte_index = '0; byte_data = '0;
        #2 sys_rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge Clock);
        #1 sys_rst_n = 1'b1;

        // MBR partition 0 at 0x2000, root cluster 2
        clr();
        mbr(0, 8'h0C, 32'h2000);
        vbr(1, 32, 2, 961, 8, 2);
        run(1'b0, nreq, lba2, lat);
        check("mbr_done", {30'd0, done0, err0}, 32'd2);
        check("mbr_nreq", nreq, 2);
        check("mbr_lba2", lba2, 32'h2000);
        check("mbr_partition", plba0, 32'h2000);
        check("mbr_fat_begin", fatb0, 32'd8224);
        check("mbr_data_begin", datab0, 32'd10146);
        check("mbr_root_dir", root0, 32'd10146);
        check("mbr_reserved", {16'd0, rs0}, 32'd32);
        check("mbr_spc_nf", {16'd0, spc0, nf0}, {16'd0, 8'd8, 8'd2});
        check("mbr_fat_size", fs0, 32'd961);
        check("mbr_root_cl", rc0, 32'd2);
        check("mbr_busy_low", {31'd0, busy0}, 32'd0);
        check("mbr_latency", lat, 10);

        // Same image, root cluster 5
        put(1, 16'h2C, 4, 32'd5);
        run(1'b0, nreq, lba2, lat);
        check("rc5_done", {31'd0, done0}, 32'd1);
        check("rc5_lba2", lba2, 32'h2000);
        check("rc5_data_begin", datab0, 32'd10146);
        check("rc5_root_dir", root0, 32'd10170);

        // Superfloppy: sector 0 is the VBR
        clr();
        vbr(0, 32, 2, 961, 8, 2);
        run(1'b0, nreq, lba2, lat);
        check("sf_done", {30'd0, done0, err0}, 32'd2);
        check("sf_nreq", nreq, 1);
        check("sf_partition", plba0, 32'd0);
        check("sf_fat_begin", fatb0, 32'd32);
        check("sf_data_begin", datab0, 32'd1954);
        check("sf_root_dir", root0, 32'd1954);
        check("sf_latency", lat, 11);

        // Bad sector-0 signature
        clr();
        mbr(0, 8'h0C, 32'h2000);
        put(0, 510, 2, 32'h0000);
        run(1'b0, nreq, lba2, lat);
        check("sig0_flags", {30'd0, done0, err0}, 32'd1);
        check("sig0_code", {29'd0, code0}, 32'd1);
        check("sig0_nreq", nreq, 1);

        // PARTITION_INDEX=1, entry 1 is not FAT32 (entry 0 is)
        clr();
        mbr(0, 8'h0C, 32'h2000);
        mbr(1, 8'h07, 32'h4000);
        vbr(1, 32, 2, 961, 8, 2);
        run(1'b1, nreq, lba2, lat);
        check("p1_flags", {30'd0, done1, err1}, 32'd1);
        check("p1_code", {29'd0, code1}, 32'd2);
        check("p1_nreq", nreq, 1);

        // VBR with zero sectors per cluster
        clr();
        mbr(0, 8'h0C, 32'h2000);
        vbr(1, 32, 2, 961, 0, 2);
        run(1'b0, nreq, lba2, lat);
        check("spc0_flags", {30'd0, done0, err0}, 32'd1);
        check("spc0_code", {29'd0, code0}, 32'd4);
        check("spc0_nreq", nreq, 2);

        // Reset during VBR reception, then a clean reparse
        clr();
        mbr(0, 8'h0C, 32'h2000);
        vbr(1, 32, 2, 961, 8, 2);
        pulse_start(1'b0);
        @(posedge Clock); #1;
        stream(0, 512);
        wait_req();
        check("abort_req_lba", slba0, 32'h2000);
        @(posedge Clock); #1;
        stream(1, 200);
        check("abort_busy", {31'd0, busy0}, 32'd1);
        sys_rst_n = 1'b0;
        #1 check_zero("abort");
        @(posedge Clock); #1;
        sys_rst_n = 1'b1;
        run(1'b0, nreq, lba2, lat);
        check("reparse_done", {30'd0, done0, err0}, 32'd2);
        check("reparse_fat_begin", fatb0, 32'd8224);
        check("reparse_root_dir", root0, 32'd10146);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
